// File: rtl/syst_feed_ctrl.sv
// Tile sequencer for the 4x4 systolic array: buffers one operand tile, clears, feeds, drains and
// returns the accumulator row. Define SYST_FEED_CTRL_SKEW_EN to apply diagonal skew in FEED.
module syst_feed_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [LANES*DATA_W-1:0]  s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [LANES*DATA_W-1:0]  arr_data_o,
  output logic                     arr_valid_o,
  output logic                     arr_clear_o,
  input  logic [LANES*ACC_W-1:0]   arr_y_i,
  output logic [LANES*ACC_W-1:0]   res_data_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     busy_o
);

  localparam int unsigned CNT_W = $clog2(2 * LANES);
  localparam int unsigned DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
`ifdef SYST_FEED_CTRL_SKEW_EN
  localparam int unsigned FEED_LEN = 2 * LANES - 1;
`else
  localparam int unsigned FEED_LEN = LANES;
`endif
  localparam logic [CNT_W-1:0] FEED_LAST = CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(LANES - 1);
  localparam logic [DRN_W-1:0] DRN_LAST  = DRN_W'(DRAIN_CYC - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StClear = 3'd2;
  localparam logic [2:0] StFeed  = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StOut   = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        t_q, t_d;
  logic [DRN_W-1:0]        drn_q, drn_d;
  logic [LANES*DATA_W-1:0] tile_q [LANES];
  logic [LANES*DATA_W-1:0] arr_data_d;
  logic [LANES*ACC_W-1:0]  res_data_d;
  logic                    ready_st;
  logic                    accept;

  assign ready_st  = (state_q == StIdle) || (state_q == StLoad);
  assign accept    = ready_st & s_valid_i;
  // State resets to IDLE, so ready must also be masked by reset itself.
  assign s_ready_o = ready_st & rst_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    t_d        = t_q;
    drn_d      = drn_q;
    res_data_d = res_data_o;
    case (state_q)
      StIdle: begin
        if (s_valid_i) begin
          cnt_d   = CNT_W'(1);
          state_d = (LANES == 1) ? StClear : StLoad;
          if (LANES == 1) cnt_d = '0;
        end
      end
      StLoad: begin
        if (s_valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == WORD_LAST) begin
            cnt_d   = '0;
            state_d = StClear;
          end
        end
      end
      StClear: begin
        t_d     = '0;
        state_d = StFeed;
      end
      StFeed: begin
        if (t_q == FEED_LAST) begin
          t_d     = '0;
          drn_d   = '0;
          state_d = StDrain;
        end else begin
          t_d = t_q + CNT_W'(1);
        end
      end
      StDrain: begin
        if (drn_q == DRN_LAST) begin
          drn_d      = '0;
          res_data_d = arr_y_i;
          state_d    = StOut;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      StOut: begin
        if (res_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state and next feed index.
  always_comb begin
    arr_data_d = '0;
    if (state_d == StFeed) begin
`ifdef SYST_FEED_CTRL_SKEW_EN
      for (int k = 0; k < LANES; k++) begin
        for (int j = 0; j < LANES; j++) begin
          if (t_d == CNT_W'(j + k)) begin
            arr_data_d[k*DATA_W +: DATA_W] = tile_q[j][k*DATA_W +: DATA_W];
          end
        end
      end
`else
      for (int j = 0; j < LANES; j++) begin
        if (t_d == CNT_W'(j)) arr_data_d = tile_q[j];
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      t_q         <= '0;
      drn_q       <= '0;
      arr_data_o  <= '0;
      arr_valid_o <= 1'b0;
      arr_clear_o <= 1'b0;
      res_data_o  <= '0;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      drn_q       <= drn_d;
      arr_data_o  <= arr_data_d;
      arr_valid_o <= (state_d == StFeed);
      arr_clear_o <= (state_d == StClear);
      res_data_o  <= res_data_d;
      res_valid_o <= (state_d == StOut);
      busy_o      <= (state_d != StIdle);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < LANES; i++) tile_q[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (accept && (cnt_q == CNT_W'(i))) tile_q[i] <= s_data_i;
      end
    end
  end

endmodule

// File: doc/syst_feed_ctrl.md
Name: syst_feed_ctrl

Overview:
- Tile sequencer in front of the 4x4 systolic array.
- Accepts one operand tile as LANES packed words over a valid/ready stream and buffers it.
- Clears the array accumulators, then feeds the buffered words into the array with diagonal skew.
- Waits out the array pipeline, captures the LANES accumulator outputs, and presents them on a held valid/ready result port.

Parameters:
- DATA_W, 8: width of one lane element.
- LANES, 4: array lanes; words per tile; input word width = LANES*DATA_W.
- ACC_W, 20: width of one array accumulator output.
- DRAIN_CYC, 4: cycles waited after the last feed cycle before capture; must be >= 1.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- s_data_i  in  LANES*DATA_W  operand word; lane k = bits [k*DATA_W +: DATA_W].
- s_valid_i  in  1  operand word valid.
- s_ready_o  out  1  operand word accepted when s_valid_i & s_ready_o.
- arr_data_o  out  LANES*DATA_W  word driven to the array data input.
- arr_valid_o  out  1  array valid input.
- arr_clear_o  out  1  one-cycle accumulator clear pulse to the array.
- arr_y_i  in  LANES*ACC_W  array outputs; lane k = bits [k*ACC_W +: ACC_W].
- res_data_o  out  LANES*ACC_W  captured result.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result consumed when res_valid_o & res_ready_i.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; word counter 0; tile buffer 0. All outputs 0: arr_data_o, arr_valid_o, arr_clear_o, res_data_o, res_valid_o, busy_o. s_ready_o 0 while reset is asserted.
- Reset mid-operation aborts the tile with no result; after release the block is in IDLE.
- States and transitions:
  - IDLE: s_ready_o=1. First accepted word is written to buf[0], counter becomes 1, go to LOAD (or straight to CLEAR if LANES==1).
  - LOAD: s_ready_o=1. Each accepted word is written to buf[cnt] and cnt increments. Gaps in s_valid_i are allowed. Accepting word LANES-1 goes to CLEAR.
  - CLEAR: exactly 1 cycle; arr_clear_o=1, arr_valid_o=0; then FEED with t=0.
  - FEED: 2*LANES-1 cycles, t = 0..2*LANES-2; arr_valid_o=1.
    - Lane k of arr_data_o = buf[t-k] lane k when 0 <= t-k < LANES, else 0.
    - After the last t, go to DRAIN.
  - DRAIN: DRAIN_CYC cycles; arr_valid_o=0, arr_data_o=0.
    - On the final DRAIN edge, arr_y_i is registered into res_data_o and the state goes to OUT.
  - OUT: res_valid_o=1 and res_data_o is held stable until res_ready_i=1. Return to IDLE on that edge.
    - res_ready_i=1 on the first OUT cycle gives a 1-cycle result.
- s_ready_o=0 in CLEAR, FEED, DRAIN and OUT; input words presented then are not accepted.
- Outputs are registered, except s_ready_o, which is a decode of the state register.
- Latency, with cycle 1 = the cycle after the edge accepting the last word:
  - CLEAR is cycle 1.
  - FEED is cycles 2..2*LANES.
  - DRAIN follows.
  - res_valid_o rises in cycle 2*LANES+DRAIN_CYC+1, i.e. cycle 13 at the defaults.
- Arithmetic: counters are sized $clog2(2*LANES) and must never wrap inside a state. No arithmetic is done on data.
- res_ready_i while res_valid_o=0 is ignored.

Optional Feature:
- Macro: SYST_FEED_CTRL_SKEW_EN.
- Defined: diagonal skew in FEED as above, 2*LANES-1 feed cycles.
- Undefined: the array skews internally. FEED lasts LANES cycles, arr_data_o = buf[t] unmodified, and res_valid_o rises in cycle LANES+DRAIN_CYC+2 (cycle 10 at the defaults).

Test Plan:
- Skew pattern, macro defined: 4 words of 0x04030201 -> arr_data_o over the 7 FEED cycles = 0x00000001, 0x00000201, 0x00030201, 0x04030201, 0x04030200, 0x04030000, 0x04000000; arr_clear_o pulses once, in the cycle before them.
- Result path: array stub drives arr_y_i = {20'd40, 20'd30, 20'd20, 20'd10} from DRAIN onward -> res_data_o equals that value, res_valid_o rises in cycle 13, busy_o high in cycles 1-13.
- Backpressure: res_ready_i held 0 for 5 cycles, then 1 -> res_valid_o and res_data_o stable for 6 cycles; s_ready_o stays 0 until IDLE is re-entered; a word presented meanwhile (0xDEADBEEF) is not accepted.
- Input gaps: s_valid_i toggled 1,0,1,0,... with words 0x02020202 -> exactly 4 accepts, then CLEAR; FEED cycle 3 output = 0x02020202.
- Reset mid-FEED: rst_i pulled low at FEED t=2 -> all outputs 0 immediately and no result is produced; a fresh tile after release completes normally.
- Macro undefined: 4 words 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> arr_data_o shows those four words unmodified in order; res_valid_o rises in cycle 10.
